// File: rtl/johnson_digit_decoder.sv
// Accepts three Johnson-coded decimal digits, converts them to a binary value
// 0..999 and scans the digits out one at a time on a seven-segment drive.
//
// state | meaning
// IDLE  | waiting for i_valid, o_ready=1
// D100  | acc <= hundreds
// D010  | acc <= acc*10 + tens
// D001  | o_value/o_err update, start display scan
// SHOW  | hundreds, tens, ones patterns, pDWELL cycles each
// BLANK | display off for pDWELL cycles, then back to IDLE
module johnson_digit_decoder #(
    parameter int pDWELL = 1000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_valid,
    input  logic [4:0] i_100,
    input  logic [4:0] i_010,
    input  logic [4:0] i_001,
    output logic       o_ready,
    output logic [9:0] o_value,
    output logic       o_value_valid,
    output logic       o_err,
    output logic [7:0] o_LED
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        D100  = 3'd1,
        D010  = 3'd2,
        D001  = 3'd3,
        SHOW  = 3'd4,
        BLANK = 3'd5
    } state_t;

    localparam logic [15:0] DWELL_LAST = 16'(pDWELL - 1);

    state_t      state, state_d;
    logic [15:0] dwell, dwell_d;
    logic [1:0]  idx, idx_d;
    logic [7:0]  led_d;
    logic        dwell_end;
    logic [4:0]  dig_h, dig_t, dig_o;
    logic [4:0]  dec_h, dec_t, dec_o;
    logic [9:0]  acc;

    // Result is {invalid, value}; an invalid code decodes to value 0.
    function automatic logic [4:0] jdec(input logic [4:0] code);
        case (code)
            5'b00000: jdec = 5'b0_0000;
            5'b00001: jdec = 5'b0_0001;
            5'b00011: jdec = 5'b0_0010;
            5'b00111: jdec = 5'b0_0011;
            5'b01111: jdec = 5'b0_0100;
            5'b11111: jdec = 5'b0_0101;
            5'b11110: jdec = 5'b0_0110;
            5'b11100: jdec = 5'b0_0111;
            5'b11000: jdec = 5'b0_1000;
            5'b10000: jdec = 5'b0_1001;
            default:  jdec = 5'b1_0000;
        endcase
    endfunction

    function automatic logic [7:0] seg(input logic [4:0] d);
        if (d[4]) begin
            seg = 8'h40;
        end else begin
            case (d[3:0])
                4'd0:    seg = 8'h3F;
                4'd1:    seg = 8'h06;
                4'd2:    seg = 8'h5B;
                4'd3:    seg = 8'h4F;
                4'd4:    seg = 8'h66;
                4'd5:    seg = 8'h6D;
                4'd6:    seg = 8'h7D;
                4'd7:    seg = 8'h07;
                4'd8:    seg = 8'h7F;
                4'd9:    seg = 8'h6F;
                default: seg = 8'h00;
            endcase
        end
    endfunction

    assign dec_h     = jdec(dig_h);
    assign dec_t     = jdec(dig_t);
    assign dec_o     = jdec(dig_o);
    assign dwell_end = (dwell == DWELL_LAST);
    assign o_ready   = (state == IDLE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
            dwell <= 16'd0;
            idx   <= 2'd0;
            o_LED <= 8'h00;
        end else begin
            state <= state_d;
            dwell <= dwell_d;
            idx   <= idx_d;
            o_LED <= led_d;
        end
    end

    always_comb begin
        state_d = state;
        dwell_d = dwell;
        idx_d   = idx;
        led_d   = o_LED;
        case (state)
            IDLE: begin
                led_d = 8'h00;
                if (i_valid) state_d = D100;
            end
            D100: state_d = D010;
            D010: state_d = D001;
            D001: begin
                state_d = SHOW;
                dwell_d = 16'd0;
                idx_d   = 2'd0;
                led_d   = seg(dec_h);
            end
            SHOW: begin
                if (dwell_end) begin
                    dwell_d = 16'd0;
                    if (idx == 2'd2) begin
                        state_d = BLANK;
                        idx_d   = 2'd0;
                        led_d   = 8'h00;
                    end else begin
                        idx_d = idx + 2'd1;
                        led_d = (idx == 2'd0) ? seg(dec_t) : seg(dec_o);
                    end
                end else begin
                    dwell_d = dwell + 16'd1;
                end
            end
            BLANK: begin
                if (dwell_end) begin
                    dwell_d = 16'd0;
                    state_d = IDLE;
                end else begin
                    dwell_d = dwell + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: digits latched only on acceptance, so later input changes are harmless.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            dig_h         <= 5'd0;
            dig_t         <= 5'd0;
            dig_o         <= 5'd0;
            acc           <= 10'd0;
            o_value       <= 10'd0;
            o_err         <= 1'b0;
            o_value_valid <= 1'b0;
        end else begin
            o_value_valid <= (state == D001);
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        dig_h <= i_100;
                        dig_t <= i_010;
                        dig_o <= i_001;
                    end
                end
                D100: acc <= {6'd0, dec_h[3:0]};
                D010: acc <= acc * 10'd10 + {6'd0, dec_t[3:0]};
                D001: begin
                    o_value <= acc * 10'd10 + {6'd0, dec_o[3:0]};
                    o_err   <= dec_h[4] | dec_t[4] | dec_o[4];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_johnson_digit_decoder.sv
// Directed bench for johnson_digit_decoder with a short dwell time.
module tb_johnson_digit_decoder;

    localparam int P = 4;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_valid = 1'b0;
    logic [4:0] i_100 = 5'd0;
    logic [4:0] i_010 = 5'd0;
    logic [4:0] i_001 = 5'd0;
    logic       o_ready;
    logic [9:0] o_value;
    logic       o_value_valid;
    logic       o_err;
    logic [7:0] o_LED;

    int tests_run = 0;
    int tests_failed = 0;

    johnson_digit_decoder #(.pDWELL(P)) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .i_valid(i_valid),
        .i_100(i_100),
        .i_010(i_010),
        .i_001(i_001),
        .o_ready(o_ready),
        .o_value(o_value),
        .o_value_valid(o_value_valid),
        .o_err(o_err),
        .o_LED(o_LED)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        i_valid = 1'b1;
        tick();
        tick();
        tests_run++;
        if (o_LED !== 8'h00 || o_value !== 10'd0 || o_err !== 1'b0 ||
            o_value_valid !== 1'b0 || o_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset: led=%h value=%0d err=%b vv=%b ready=%b, want led=00 value=0 err=0 vv=0 ready=1",
                     o_LED, o_value, o_err, o_value_valid, o_ready);
        end
        i_valid = 1'b0;
        i_rst = 1'b0;
        tick();
        tests_run++;
        if (o_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_idle: ready=%b want 1", o_ready);
        end
    endtask

    // Accepts one sample and follows it through the whole display scan.
    task automatic test_sample(input string name, input logic [4:0] h, t, o,
                               input logic [9:0] exp_val, input logic exp_err,
                               input logic [7:0] l0, l1, l2);
        logic [7:0] exp_led;
        int guard;
        guard = 0;
        while (o_ready !== 1'b1 && guard < 100) begin
            tick();
            guard++;
        end
        tests_run++;
        if (o_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s_ready_timeout: ready=%b want 1", name, o_ready);
        end
        i_valid = 1'b1;
        i_100 = h;
        i_010 = t;
        i_001 = o;
        tick();
        i_valid = 1'b0;
        i_100 = ~h;
        i_010 = ~t;
        i_001 = ~o;
        tests_run++;
        if (o_ready !== 1'b0 || o_value_valid !== 1'b0 || o_LED !== 8'h00) begin
            tests_failed++;
            $display("FAIL %s_accept: ready=%b vv=%b led=%h, want ready=0 vv=0 led=00",
                     name, o_ready, o_value_valid, o_LED);
        end
        tick();
        tick();
        tests_run++;
        if (o_value_valid !== 1'b0 || o_LED !== 8'h00) begin
            tests_failed++;
            $display("FAIL %s_early_valid: vv=%b led=%h, want vv=0 led=00", name, o_value_valid, o_LED);
        end
        tick();
        tests_run++;
        if (o_value_valid !== 1'b1 || o_value !== exp_val || o_err !== exp_err) begin
            tests_failed++;
            $display("FAIL %s_result: vv=%b value=%0d err=%b, want vv=1 value=%0d err=%b",
                     name, o_value_valid, o_value, o_err, exp_val, exp_err);
        end
        for (int c = 0; c < 4 * P; c++) begin
            if (c < P)          exp_led = l0;
            else if (c < 2 * P) exp_led = l1;
            else if (c < 3 * P) exp_led = l2;
            else                exp_led = 8'h00;
            tests_run++;
            if (o_LED !== exp_led || o_ready !== 1'b0 ||
                (c > 0 && o_value_valid !== 1'b0)) begin
                tests_failed++;
                $display("FAIL %s_scan[%0d]: led=%h ready=%b vv=%b, want led=%h ready=0 vv=%0d",
                         name, c, o_LED, o_ready, o_value_valid, exp_led, (c == 0) ? 1 : 0);
            end
            tick();
        end
        tests_run++;
        if (o_ready !== 1'b1 || o_LED !== 8'h00 || o_value !== exp_val || o_err !== exp_err) begin
            tests_failed++;
            $display("FAIL %s_done: ready=%b led=%h value=%0d err=%b, want ready=1 led=00 value=%0d err=%b",
                     name, o_ready, o_LED, o_value, o_err, exp_val, exp_err);
        end
    endtask

    task automatic test_ignore_valid();
        i_valid = 1'b1;
        i_100 = 5'b00011;
        i_010 = 5'b11110;
        i_001 = 5'b10000;
        tick();
        i_valid = 1'b0;
        tick();
        tick();
        tick();
        tick();
        i_valid = 1'b1;
        i_100 = 5'b10000;
        i_010 = 5'b10000;
        i_001 = 5'b10000;
        tick();
        i_valid = 1'b0;
        for (int c = 0; c < 4 * P - 2; c++) begin
            tests_run++;
            if (o_value_valid !== 1'b0 || o_value !== 10'd269) begin
                tests_failed++;
                $display("FAIL ignore_busy[%0d]: vv=%b value=%0d, want vv=0 value=269",
                         c, o_value_valid, o_value);
            end
            tick();
        end
        tests_run++;
        if (o_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL ignore_done: ready=%b want 1", o_ready);
        end
        tick();
        tick();
        tests_run++;
        if (o_ready !== 1'b1 || o_value_valid !== 1'b0 || o_value !== 10'd269) begin
            tests_failed++;
            $display("FAIL ignore_no_queue: ready=%b vv=%b value=%0d, want ready=1 vv=0 value=269",
                     o_ready, o_value_valid, o_value);
        end
    endtask

    task automatic test_reset_mid();
        i_valid = 1'b1;
        i_100 = 5'b00011;
        i_010 = 5'b11110;
        i_001 = 5'b10000;
        tick();
        i_valid = 1'b0;
        for (int c = 0; c < P + 4; c++) tick();
        tests_run++;
        if (o_LED !== 8'h7D || o_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstmid_phase2: led=%h ready=%b, want led=7D ready=0", o_LED, o_ready);
        end
        i_rst = 1'b1;
        i_valid = 1'b1;
        tick();
        tests_run++;
        if (o_LED !== 8'h00 || o_value !== 10'd0 || o_ready !== 1'b1 ||
            o_err !== 1'b0 || o_value_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstmid_abort: led=%h value=%0d ready=%b err=%b vv=%b, want 00 0 1 0 0",
                     o_LED, o_value, o_ready, o_err, o_value_valid);
        end
        tick();
        tests_run++;
        if (o_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL rstmid_priority: ready=%b want 1", o_ready);
        end
        i_rst = 1'b0;
        i_valid = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_sample("basic", 5'b00011, 5'b11110, 5'b10000, 10'd269, 1'b0, 8'h5B, 8'h7D, 8'h6F);
        test_sample("bad_tens", 5'b00011, 5'b00101, 5'b10000, 10'd209, 1'b1, 8'h5B, 8'h40, 8'h6F);
        test_sample("max", 5'b10000, 5'b10000, 5'b10000, 10'd999, 1'b0, 8'h6F, 8'h6F, 8'h6F);
        test_sample("zero", 5'b00000, 5'b00000, 5'b00000, 10'd0, 1'b0, 8'h3F, 8'h3F, 8'h3F);
        test_sample("mixed", 5'b11000, 5'b01111, 5'b00111, 10'd843, 1'b0, 8'h7F, 8'h66, 8'h4F);
        test_ignore_valid();
        test_reset_mid();
        test_sample("after_rst", 5'b00011, 5'b00101, 5'b10000, 10'd209, 1'b1, 8'h5B, 8'h40, 8'h6F);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/johnson_digit_decoder.md
JOHNSON_DIGIT_DECODER -- requirements
Module: johnson_digit_decoder

Interface
REQ-001 Parameter pDWELL, default 1000: i_clk cycles each display phase lasts; legal range 1..65535.
REQ-002 The block SHALL use one clock, i_clk; reset i_rst is synchronous and active-high.
REQ-003 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 i_rst  input  1  synchronous active-high reset.
REQ-005 i_valid  input  1  sample request; accepted only when o_ready=1.
REQ-006 i_100  input  5  hundreds digit, 5-bit Johnson (decade) code.
REQ-007 i_010  input  5  tens digit, Johnson code.
REQ-008 i_001  input  5  ones digit, Johnson code.
REQ-009 o_ready  output  1  high only in IDLE.
REQ-010 o_value  output  10  decoded binary value 0..999.
REQ-011 o_value_valid  output  1  one-cycle pulse when o_value updates.
REQ-012 o_err  output  1  at least one digit of the last accepted sample was an invalid code.
REQ-013 o_LED  output  8  seven-segment drive: bit0=a .. bit6=g, bit7 unused, always 0.

Function
REQ-014 Johnson decode map: 00000=0, 00001=1, 00011=2, 00111=3, 01111=4, 11111=5, 11110=6, 11100=7, 11000=8, 10000=9; every other code is invalid.
REQ-015 An invalid digit SHALL contribute 0 to o_value and display as a dash, 0x40.
REQ-016 Segment patterns: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F (hex); blank=00.
REQ-017 FSM states: IDLE, D100, D010, D001, SHOW, BLANK.
REQ-018 IDLE: on an edge with i_valid=1, the block latches i_100/i_010/i_001 and goes to D100; with i_valid=0 it stays in IDLE.
REQ-019 D100: acc <= dec(h); go to D010.
REQ-020 D010: acc <= acc*10 + dec(t); go to D001.
REQ-021 D001: o_value <= acc*10 + dec(o); o_err <= OR of invalid flags; o_value_valid=1 for the following cycle only; go to SHOW with digit index 0 and dwell count 0.
REQ-022 Latency: o_value_valid is high in the 3rd cycle after the accepting edge.
REQ-023 acc SHALL be 10 bits wide; 999 is the maximum, so no overflow handling is needed.
REQ-024 SHOW: o_LED shows the hundreds, tens, then ones pattern, each for exactly pDWELL cycles; the dwell counter wraps at pDWELL-1 and advances the index.
REQ-025 After the ones phase the block enters BLANK (o_LED=00) for pDWELL cycles, then returns to IDLE.
REQ-026 o_LED SHALL be 00 in IDLE, D100, D010 and D001.
REQ-027 o_LED SHALL be registered, changing on the same edge as the state/index change.
REQ-028 i_valid outside IDLE SHALL be ignored: no latch, no queueing.
REQ-029 Latched digits SHALL be immune to input changes after acceptance.
REQ-030 o_value and o_err hold their values until the next D001 update.
REQ-031 Total busy time per sample is 3 + 4*pDWELL cycles.

Reset
REQ-032 While i_rst=1: state=IDLE; o_value=0, o_value_valid=0, o_err=0, o_LED=00, acc=0, index=0, dwell=0.
REQ-033 i_rst has priority over i_valid; a sample is never accepted on an edge with i_rst=1.
REQ-034 Reset mid-operation (any state) SHALL abort the operation: outputs go to reset values after the next edge and o_ready=1 after that edge.
REQ-035 o_ready SHALL be 1 during reset, because the state is IDLE.

Verification
REQ-036 Reset: i_rst=1 for 2 cycles -> o_LED=00, o_value=0, o_err=0, o_value_valid=0, o_ready=1.
REQ-037 pDWELL=4; accept h=00011, t=11110, o=10000 -> o_value=269 with o_value_valid 3 cycles later, o_err=0; o_LED then shows 5B x4, 7D x4, 6F x4, 00 x4 cycles, then o_ready=1.
REQ-038 Invalid tens: h=00011, t=00101, o=10000 -> o_value=209, o_err=1; the tens phase shows 40.
REQ-039 Boundaries: all digits 10000 -> o_value=999; all 00000 -> o_value=0 and display 3F,3F,3F; o_err=0 in both cases.
REQ-040 i_valid pulsed with new digits during SHOW -> ignored; o_value unchanged; no extra o_value_valid.
REQ-041 i_rst asserted in the second SHOW phase -> o_LED=00, o_value=0, o_ready=1 after the next edge; a new sample is accepted normally afterward.
